// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane helpers for the data memory controller
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_HALF: misaligned = off[0];
         SIZE_WORD: misaligned = (off != 2'b00);
         default:   misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: lane_en = 4'b0001 << off;
         SIZE_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: lane_en = 4'b1111;
         default:   lane_en = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - MEM-stage request/response bus of the data memory
interface data_memory_ctrl_if #(parameter int ADDR_W = 32);
   logic              req_i;
   logic              we_i;
   logic [1:0]        size_i;
   logic              unsigned_i;
   logic [ADDR_W-1:0] addr_i;
   logic [31:0]       wdata_i;
   logic              ready_o;
   logic              resp_valid_o;
   logic              resp_err_o;
   logic [31:0]       rdata_o;

   modport master (output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
                   input  ready_o, resp_valid_o, resp_err_o, rdata_o);
   modport slave  (input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
                   output ready_o, resp_valid_o, resp_err_o, rdata_o);
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane merge and load lane extract/extend
module dmem_lane_align (
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        unsigned_ld,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   output logic [31:0] merged_word,
   output logic [31:0] load_data
);
   import dmem_pkg::*;

   logic [3:0]  be;
   logic [31:0] wrep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign be       = lane_en(size, off);
   assign byte_sel = old_word[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? old_word[31:16] : old_word[15:0];

   // Replicating the right-justified data lets every lane pick from the same position.
   always_comb begin
      case (size)
         SIZE_BYTE: wrep = {4{wdata[7:0]}};
         SIZE_HALF: wrep = {2{wdata[15:0]}};
         default:   wrep = wdata;
      endcase
      merged_word = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged_word[8*b +: 8] = wrep[8*b +: 8];
      end
   end

   always_comb begin
      case (size)
         SIZE_BYTE: load_data = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
         SIZE_HALF: load_data = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
         default:   load_data = old_word;
      endcase
   end
endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - latency-configurable data memory with req/ready and registered response
module data_memory_ctrl #(
   parameter int DEPTH   = 128,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 2
) (
   input logic              clk_i,
   input logic              rst_i,
   data_memory_ctrl_if.slave bus
);
   import dmem_pkg::*;

   localparam int                IDX_W   = $clog2(DEPTH);
   localparam int                CNT_W   = $clog2(LATENCY + 1);
   localparam logic [ADDR_W-2:0] DEPTH_W = (ADDR_W-1)'(DEPTH);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we;
   logic              lat_uns;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem [0:DEPTH-1];

   logic [ADDR_W-3:0] word_addr;
   logic [IDX_W-1:0]  idx;
   logic              out_of_range;
   logic              err;
   logic              accept;
   logic [31:0]       old_word;
   logic [31:0]       merged_word;
   logic [31:0]       load_data;

   assign word_addr    = lat_addr[ADDR_W-1:2];
   assign idx          = word_addr[IDX_W-1:0];
   // Full-width compare so out-of-range addresses never alias onto a low index.
   assign out_of_range = ({1'b0, word_addr} >= DEPTH_W);
   assign err          = (lat_size == SIZE_ILLEGAL) || misaligned(lat_size, lat_addr[1:0]) || out_of_range;
   assign old_word     = mem[idx];

   assign bus.ready_o      = (state != ST_WAIT);
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_err_o   = resp_err_q;
   assign bus.rdata_o      = rdata_q;
   assign accept           = bus.req_i && bus.ready_o;

   dmem_lane_align u_align (
      .size        (lat_size),
      .off         (lat_addr[1:0]),
      .unsigned_ld (lat_uns),
      .wdata       (lat_wdata),
      .old_word    (old_word),
      .merged_word (merged_word),
      .load_data   (load_data)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         lat_we       <= 1'b0;
         lat_uns      <= 1'b0;
         lat_size     <= SIZE_BYTE;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         if (state == ST_RESP) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err;
            if (!lat_we) rdata_q <= err ? 32'h0 : load_data;
         end
         if (accept) begin
            lat_we    <= bus.we_i;
            lat_uns   <= bus.unsigned_i;
            lat_size  <= bus.size_i;
            lat_addr  <= bus.addr_i;
            lat_wdata <= bus.wdata_i;
         end
         case (state)
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= ST_RESP;
            end
            default: begin
               if (accept) begin
                  state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                  cnt   <= CNT_W'(LATENCY - 1);
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Reset drops any op in flight because the write is gated by the RESP state.
   always_ff @(posedge clk_i) begin
      if (state == ST_RESP && lat_we && !err) mem[idx] <= merged_word;
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl (LATENCY 2 and 1 builds)
module tb_data_memory_ctrl;
   import dmem_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   data_memory_ctrl_if #(.ADDR_W(32)) b2 ();
   data_memory_ctrl_if #(.ADDR_W(32)) b1 ();

   data_memory_ctrl #(.DEPTH(128), .ADDR_W(32), .LATENCY(2)) dut2 (.clk_i(clk), .rst_i(rst_n), .bus(b2.slave));
   data_memory_ctrl #(.DEPTH(128), .ADDR_W(32), .LATENCY(1)) dut1 (.clk_i(clk), .rst_i(rst_n), .bus(b1.slave));

   typedef struct packed {
      logic        is_load;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   logic [31:0] last_rd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b2.resp_valid_o) begin
         pulses++;
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_resp observed=pulse expected=none");
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_err", b2.resp_err_o, e.err);
            if (e.is_load) begin
               chk("load_rdata", b2.rdata_o, e.rdata);
               last_rd = e.rdata;
            end else begin
               chk("store_keeps_rdata", b2.rdata_o, last_rd);
            end
         end
      end else if (rst_n) begin
         chk("err_without_valid", b2.resp_err_o, 1'b0);
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic eerr, input logic [31:0] erd);
      int   n = 0;
      exp_t e;
      b2.req_i = 1'b1; b2.we_i = we; b2.size_i = sz; b2.unsigned_i = uns; b2.addr_i = a; b2.wdata_i = wd;
      while (!b2.ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue_ready", b2.ready_o, 1'b1);
      e.is_load = ~we; e.err = eerr; e.rdata = erd;
      sb.push_back(e);
      @(negedge clk);
      b2.req_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   j;
      int   p0;
      exp_t e;
      b2.req_i = 1'b0; b2.we_i = 1'b0; b2.size_i = SIZE_WORD; b2.unsigned_i = 1'b0; b2.addr_i = '0; b2.wdata_i = '0;
      b1.req_i = 1'b0; b1.we_i = 1'b0; b1.size_i = SIZE_WORD; b1.unsigned_i = 1'b0; b1.addr_i = '0; b1.wdata_i = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", b2.ready_o, 1'b1);
      chk("rst_valid", b2.resp_valid_o, 1'b0);
      chk("rst_err", b2.resp_err_o, 1'b0);
      chk("rst_rdata", b2.rdata_o, 32'h0);
      chk("rst_l1_ready", b1.ready_o, 1'b1);
      chk("rst_l1_valid", b1.resp_valid_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: word store timing, then word load
      issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      chk("t1_valid_e0", b2.resp_valid_o, 1'b0);
      chk("t1_ready_wait", b2.ready_o, 1'b0);
      @(negedge clk);
      chk("t1_valid_e1", b2.resp_valid_o, 1'b0);
      @(negedge clk);
      chk("t1_valid_e2", b2.resp_valid_o, 1'b1);
      @(negedge clk);
      chk("t1_valid_e3", b2.resp_valid_o, 1'b0);
      issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
      drain();

      // 2: byte/half stores and extension
      issue(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h00000080, 1'b0, 32'h0);
      issue(1'b0, SIZE_BYTE, 1'b0, 32'h11, 32'h0, 1'b0, 32'hFFFFFF80);
      issue(1'b0, SIZE_BYTE, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000080);
      issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD80EF);
      issue(1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h5555ABCD, 1'b0, 32'h0);
      issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hABCD80EF);
      drain();

      // 3: error cases
      issue(1'b1, SIZE_WORD, 1'b0, 32'h0, 32'h11223344, 1'b0, 32'h0);
      issue(1'b0, SIZE_HALF, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
      issue(1'b1, SIZE_WORD, 1'b0, 32'h200, 32'hFFFFFFFF, 1'b1, 32'h0);
      issue(1'b0, SIZE_ILLEGAL, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);
      issue(1'b0, SIZE_WORD, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0);
      issue(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11223344);
      drain();

      // 4: req held high for three back-to-back loads
      p0 = pulses;
      j  = 0;
      b2.req_i = 1'b1; b2.we_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("b2b_ready", b2.ready_o, (i % 2 == 0) ? 1'b1 : 1'b0);
         if (b2.ready_o && j < 3) begin
            case (j)
               0: begin b2.size_i = SIZE_WORD; b2.unsigned_i = 1'b0; b2.addr_i = 32'h10; e.rdata = 32'hABCD80EF; end
               1: begin b2.size_i = SIZE_BYTE; b2.unsigned_i = 1'b1; b2.addr_i = 32'h11; e.rdata = 32'h00000080; end
               default: begin b2.size_i = SIZE_HALF; b2.unsigned_i = 1'b0; b2.addr_i = 32'h12; e.rdata = 32'hFFFFABCD; end
            endcase
            e.is_load = 1'b1; e.err = 1'b0;
            sb.push_back(e);
            j++;
         end
         @(negedge clk);
      end
      b2.req_i = 1'b0;
      drain();
      chk("b2b_pulses", pulses - p0, 3);

      // 5: reset while a store waits
      issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("t5_ready", b2.ready_o, 1'b1);
      chk("t5_valid", b2.resp_valid_o, 1'b0);
      chk("t5_err", b2.resp_err_o, 1'b0);
      chk("t5_rdata", b2.rdata_o, 32'h0);
      void'(sb.pop_back());
      last_rd = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hABCD80EF);
      drain();

      // 6: LATENCY=1 build, store then load of the same word back-to-back
      b1.req_i = 1'b1; b1.we_i = 1'b1; b1.size_i = SIZE_WORD; b1.addr_i = 32'h20; b1.wdata_i = 32'h12345678;
      @(negedge clk);
      chk("l1_valid_e0", b1.resp_valid_o, 1'b0);
      chk("l1_ready_resp", b1.ready_o, 1'b1);
      b1.we_i = 1'b0;
      @(negedge clk);
      chk("l1_store_valid", b1.resp_valid_o, 1'b1);
      chk("l1_store_err", b1.resp_err_o, 1'b0);
      b1.req_i = 1'b0;
      @(negedge clk);
      chk("l1_load_valid", b1.resp_valid_o, 1'b1);
      chk("l1_load_rdata", b1.rdata_o, 32'h12345678);
      @(negedge clk);
      chk("l1_idle_valid", b1.resp_valid_o, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
